// File: rtl/write_logic_regs_header.sv
// Ingress write-side controller for the 4-line header buffer: AXI-Stream bytes in, registered RAM write strobes out.
// Optional build macro WR_LOGIC_DROP_OVERSIZE_EN: abort (do not commit) frames longer than one line.
module write_logic_regs_header #(
    parameter int LINE_W = 2,
    parameter int CHAR_W = 11
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    input  logic                     rd_frame_done,
    output logic [LINE_W+CHAR_W-1:0] wr_ptr_rgs,
    output logic [7:0]               tdata_rgs,
    output logic                     we_rgs,
    output logic                     tlastarray_cs_rgs,
    output logic [LINE_W:0]          frames_avail,
    output logic                     trunc_err,
    output logic [1:0]               dbg_state_o
);

    localparam int PTR_W = LINE_W + CHAR_W;
    localparam logic [CHAR_W-1:0] CHAR_LAST = '1;
    localparam logic [CHAR_W-1:0] CHAR_ONE  = CHAR_W'(1);
    localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
    localparam logic [LINE_W:0]   FRAME_ONE = (LINE_W+1)'(1);
    localparam logic [LINE_W+1:0] LINES_CNT = (LINE_W+2)'(1 << LINE_W);

    // Handshake: a byte transfers on a rising edge where s_axis_tvalid && s_axis_tready;
    // s_axis_tready depends only on state and occupancy, never on s_axis_tvalid.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [7:0]          data_q, data_d;
    logic                we_q, we_d;
    logic                cs_q, cs_d;
    logic                trunc_q, trunc_d;
    logic                commit_p1_q, commit_d;
    logic                commit_p2_q;
    logic [LINE_W:0]     frames_q, frames_d;
    logic [LINE_W+1:0]   occ;
    logic                tready;
    logic                release_ok;

    // Commits still in the two-stage pipeline already own a line.
    always_comb begin
        occ = {1'b0, frames_q}
            + {{(LINE_W+1){1'b0}}, commit_p1_q}
            + {{(LINE_W+1){1'b0}}, commit_p2_q};
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        char_d   = char_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        cs_d     = 1'b0;
        trunc_d  = 1'b0;
        commit_d = 1'b0;
        tready   = 1'b0;

        case (state_q)
            IDLE: begin
                tready = (occ < LINES_CNT);
                if (s_axis_tvalid && tready) begin
                    we_d   = 1'b1;
                    ptr_d  = {line_q, char_q};
                    data_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        cs_d     = 1'b1;
                        commit_d = 1'b1;
                        line_d   = line_q + LINE_ONE;
                        char_d   = '0;
                    end else begin
                        char_d  = char_q + CHAR_ONE;
                        state_d = BODY;
                    end
                end
            end

            BODY: begin
                tready = 1'b1;
                if (s_axis_tvalid) begin
                    we_d   = 1'b1;
                    ptr_d  = {line_q, char_q};
                    data_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        cs_d     = 1'b1;
                        commit_d = 1'b1;
                        line_d   = line_q + LINE_ONE;
                        char_d   = '0;
                        state_d  = IDLE;
                    end else if (char_q == CHAR_LAST) begin
                        trunc_d = 1'b1;
                        state_d = DISCARD;
`ifdef WR_LOGIC_DROP_OVERSIZE_EN
                        // Line stays reserved for the next frame; nothing is published.
                        char_d  = '0;
`else
                        cs_d     = 1'b1;
                        commit_d = 1'b1;
                        line_d   = line_q + LINE_ONE;
                        char_d   = '0;
`endif
                    end else begin
                        char_d = char_q + CHAR_ONE;
                    end
                end
            end

            DISCARD: begin
                tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A release with nothing committed is dropped so the count cannot wrap.
    assign release_ok = rd_frame_done && (frames_q != '0);

    always_comb begin
        frames_d = frames_q;
        case ({commit_p2_q, release_ok})
            2'b10:   frames_d = frames_q + FRAME_ONE;
            2'b01:   frames_d = frames_q - FRAME_ONE;
            default: frames_d = frames_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            line_q      <= '0;
            char_q      <= '0;
            ptr_q       <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            cs_q        <= 1'b0;
            trunc_q     <= 1'b0;
            commit_p1_q <= 1'b0;
            commit_p2_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            char_q      <= char_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            cs_q        <= cs_d;
            trunc_q     <= trunc_d;
            commit_p1_q <= commit_d;
            commit_p2_q <= commit_p1_q;
            frames_q    <= frames_d;
        end
    end

    assign s_axis_tready     = tready;
    assign wr_ptr_rgs        = ptr_q;
    assign tdata_rgs         = data_q;
    assign we_rgs            = we_q;
    assign tlastarray_cs_rgs = cs_q;
    assign trunc_err         = trunc_q;
    assign frames_avail      = frames_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_write_logic_regs_header.sv
// Directed bench for write_logic_regs_header: scoreboarded strobes plus occupancy and reset checks.
// Honours WR_LOGIC_DROP_OVERSIZE_EN the same way as the design.
module tb_write_logic_regs_header;

    logic        clk;
    logic        reset_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        rd_frame_done;
    logic [12:0] wr_ptr_rgs;
    logic [7:0]  tdata_rgs;
    logic        we_rgs;
    logic        tlastarray_cs_rgs;
    logic [2:0]  frames_avail;
    logic        trunc_err;
    logic [1:0]  dbg_state_o;

    write_logic_regs_header #(.LINE_W(2), .CHAR_W(11)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .rd_frame_done     (rd_frame_done),
        .wr_ptr_rgs        (wr_ptr_rgs),
        .tdata_rgs         (tdata_rgs),
        .we_rgs            (we_rgs),
        .tlastarray_cs_rgs (tlastarray_cs_rgs),
        .frames_avail      (frames_avail),
        .trunc_err         (trunc_err),
        .dbg_state_o       (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int trunc_cnt = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: each strobe pops one expected {cs, ptr, data}
    always @(negedge clk) begin
        if (we_rgs === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {19'd0, tlastarray_cs_rgs, wr_ptr_rgs}, 32'hFFFF_FFFF);
            end else begin
                check("strobe", {10'd0, tlastarray_cs_rgs, wr_ptr_rgs, tdata_rgs}, {10'd0, exp_q.pop_front()});
            end
        end else if (tlastarray_cs_rgs === 1'b1) begin
            check("cs_without_we", 32'd1, 32'd0);
        end
        if (trunc_err === 1'b1) begin
            trunc_cnt++;
            check("trunc_align", {18'd0, we_rgs, wr_ptr_rgs}, {18'd0, 1'b1, 13'h07FF});
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic cs, input logic [12:0] ptr, input logic [7:0] d);
        exp_q.push_back({cs, ptr, d});
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        rd_frame_done = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited;
        waited = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready === 1'b1) break;
            waited++;
            if (waited > 64) begin
                check("tready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pulse_release();
        rd_frame_done = 1'b1;
        tick();
        rd_frame_done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, {31'd0, we_rgs}, 32'd0);
        check({tag, "_cs"}, {31'd0, tlastarray_cs_rgs}, 32'd0);
        check({tag, "_trunc"}, {31'd0, trunc_err}, 32'd0);
        check({tag, "_ptr"}, {19'd0, wr_ptr_rgs}, 32'd0);
        check({tag, "_data"}, {24'd0, tdata_rgs}, 32'd0);
        check({tag, "_frames"}, {29'd0, frames_avail}, 32'd0);
        check({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd1);
        check({tag, "_state"}, {30'd0, dbg_state_o}, 32'd0);
    endtask

    initial begin
        int base;
        logic [7:0] d;

        // reset state
        do_reset();
        @(negedge clk);
        check_idle_outputs("reset");
        tick();

        // single 16-byte frame
        for (int i = 0; i < 16; i++) push(i == 15, 13'(i), 8'(i));
        for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
        @(negedge clk);
        check("t1_frames_n", {29'd0, frames_avail}, 32'd0);
        @(negedge clk);
        check("t1_frames_n1", {29'd0, frames_avail}, 32'd0);
        @(negedge clk);
        check("t1_frames_n2", {29'd0, frames_avail}, 32'd1);
        check("t1_queue_empty", exp_q.size(), 32'd0);
        tick();

        // five 4-byte frames, occupancy limit
        do_reset();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++) push(i == 3, 13'((f << 11) | i), 8'((f << 4) | i));
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++) send_byte(8'((f << 4) | i), i == 3);
        @(negedge clk);
        check("t2_tready_full_pending", {31'd0, s_axis_tready}, 32'd0);
        check("t2_state_idle", {30'd0, dbg_state_o}, 32'd0);
        tick();
        repeat (3) tick();
        @(negedge clk);
        check("t2_frames_4", {29'd0, frames_avail}, 32'd4);
        check("t2_tready_full", {31'd0, s_axis_tready}, 32'd0);
        tick();
        base = strobe_cnt;
        s_axis_tdata  = 8'h40;
        s_axis_tvalid = 1'b1;
        repeat (3) tick();
        s_axis_tvalid = 1'b0;
        check("t2_blocked_no_strobe", strobe_cnt - base, 32'd0);
        pulse_release();
        @(negedge clk);
        check("t2_frames_after_rel", {29'd0, frames_avail}, 32'd3);
        check("t2_tready_after_rel", {31'd0, s_axis_tready}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) push(i == 3, 13'(i), 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), i == 3);
        repeat (3) tick();
        @(negedge clk);
        check("t2_frames_back_4", {29'd0, frames_avail}, 32'd4);
        check("t2_queue_empty", exp_q.size(), 32'd0);
        tick();

        // release on empty, then commit and release in the same cycle
        do_reset();
        pulse_release();
        @(negedge clk);
        check("t3_release_empty", {29'd0, frames_avail}, 32'd0);
        tick();
        push(1'b1, 13'h0000, 8'hA0);
        push(1'b1, 13'h0800, 8'hB0);
        push(1'b1, 13'h1000, 8'hC0);
        send_byte(8'hA0, 1'b1);
        send_byte(8'hB0, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        check("t3_frames_2", {29'd0, frames_avail}, 32'd2);
        tick();
        send_byte(8'hC0, 1'b1);
        tick();
        pulse_release();
        @(negedge clk);
        check("t3_frames_same_cycle", {29'd0, frames_avail}, 32'd2);
        repeat (3) tick();
        @(negedge clk);
        check("t3_frames_stable", {29'd0, frames_avail}, 32'd2);
        check("t3_queue_empty", exp_q.size(), 32'd0);
        tick();

        // 2050-byte oversize frame
        do_reset();
        base = strobe_cnt;
        for (int i = 0; i < 2048; i++) begin
`ifdef WR_LOGIC_DROP_OVERSIZE_EN
            push(1'b0, 13'(i), 8'(i));
`else
            push(i == 2047, 13'(i), 8'(i));
`endif
        end
        for (int i = 0; i < 2048; i++) begin
            d = 8'(i);
            send_byte(d, 1'b0);
        end
        @(negedge clk);
        check("t4_state_discard", {30'd0, dbg_state_o}, 32'd2);
        tick();
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEF, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        check("t4_strobe_count", strobe_cnt - base, 32'd2048);
        check("t4_trunc_once", trunc_cnt, 32'd1);
`ifdef WR_LOGIC_DROP_OVERSIZE_EN
        check("t4_frames", {29'd0, frames_avail}, 32'd0);
        tick();
        push(1'b0, 13'h0000, 8'h51);
        push(1'b1, 13'h0001, 8'h52);
`else
        check("t4_frames", {29'd0, frames_avail}, 32'd1);
        tick();
        push(1'b0, 13'h0800, 8'h51);
        push(1'b1, 13'h0801, 8'h52);
`endif
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b1);
        repeat (4) tick();
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // tvalid toggled every other cycle
        do_reset();
        base = strobe_cnt;
        for (int i = 0; i < 6; i++) push(i == 5, 13'(i), 8'(8'h20 + i));
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h20 + i), i == 5);
            tick();
        end
        repeat (2) tick();
        check("t5_strobe_count", strobe_cnt - base, 32'd6);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b0, 13'(i), 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        tick();
        for (int i = 0; i < 3; i++) push(i == 2, 13'(i), 8'(8'h60 + i));
        for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i), i == 2);
        repeat (3) tick();
        @(negedge clk);
        check("t6_frames_1", {29'd0, frames_avail}, 32'd1);
        check("t6_queue_empty", exp_q.size(), 32'd0);
        check("total_trunc", trunc_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/write_logic_regs_header.md
# write_logic_regs_header

Ingress write-side controller for the 4-line header buffer. It accepts an 8-bit AXI-Stream frame and turns each accepted byte into a registered write strobe, byte and 13-bit pointer {line, char index}. It marks the last byte of every frame for the tlast-pointer array and keeps the count of committed lines. It sits directly upstream of read_logic_regs_header, which consumes the pointer/strobe bus and returns a per-frame release pulse.

## Interface
- LINE_W, 2: line-address width; 2^LINE_W lines (4).
- CHAR_W, 11: byte-index width per line; 2^CHAR_W bytes max per line (2048).
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- s_axis_tdata  in  8  frame byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- rd_frame_done  in  1  one-cycle pulse from the read side; one committed line has been released.
- wr_ptr_rgs  out  LINE_W+CHAR_W (13)  {line, char index} of the byte on tdata_rgs.
- tdata_rgs  out  8  registered byte.
- we_rgs  out  1  write strobe for the byte, VLAN nibble and tlast entry.
- tlastarray_cs_rgs  out  1  qualifies we_rgs as a tlast-array write; high only on the last stored byte of a line.
- frames_avail  out  LINE_W+1 (3)  committed, unreleased lines, range 0..4.
- trunc_err  out  1  one-cycle pulse when a frame exceeds 2^CHAR_W bytes.

## Operation
- States:
  - IDLE: waiting for first byte.
  - BODY: writing the current line.
  - DISCARD: swallowing the tail of an oversize frame until tlast.
- s_axis_tready:
  - IDLE: high iff frames_avail < 4.
  - BODY and DISCARD: always high. The line is already reserved, because commit happens only at frame end.
- Accepted byte in IDLE:
  - Written at char 0 of wr_line.
  - With tlast: single-byte frame; commit, stay in IDLE.
  - Without tlast: go to BODY.
- Accepted byte in BODY:
  - Written at char_cnt; char_cnt increments.
  - With tlast: tlastarray_cs_rgs=1, commit, go to IDLE.
- Byte at char index 2^CHAR_W−1 without tlast (overflow):
  - trunc_err pulses.
  - Default build: the byte is written with tlastarray_cs_rgs=1, the line commits truncated, and the FSM goes to DISCARD.
- DISCARD: accepted bytes produce no strobes. The tlast byte returns the FSM to IDLE.
- Commit:
  - wr_line increments mod 4; char_cnt clears.
  - frames_avail increments.
- rd_frame_done: frames_avail decrements.
  - Commit and release in the same cycle: count unchanged.
  - Release while frames_avail=0: ignored.
- s_axis_tvalid low mid-frame: no strobe, pointer held.
- Reset values:
  - FSM IDLE; wr_line=0; char_cnt=0; frames_avail=0.
  - we_rgs=0, tlastarray_cs_rgs=0, trunc_err=0, wr_ptr_rgs=0, tdata_rgs=0.
  - s_axis_tready=1 in the cycle after reset deasserts.
- Reset mid-frame: the partial frame is lost. Lines already committed are forgotten (frames_avail=0).

## Timing
- Byte accepted at edge N: wr_ptr_rgs, tdata_rgs, we_rgs and tlastarray_cs_rgs are valid for the cycle after edge N. The RAM writes at edge N+1.
- frames_avail increments at edge N+2 for a tlast byte accepted at edge N. The downstream asynchronous-read tlast array therefore already holds the pointer when the count is seen.
- trunc_err is aligned with the overflow byte's strobe cycle (edge N+1).
- s_axis_tready is combinational from state and frames_avail; no combinational path from tvalid.
- Full throughput: one byte per cycle, with back-to-back frames and no idle cycle between tlast and the next first byte.
- Pending commit counts as occupancy. tready in IDLE uses frames_avail plus any commit in flight, so a fifth frame can never start.

## Configuration
- WR_LOGIC_DROP_OVERSIZE_EN:
  - Defined: an oversize frame is aborted. The overflow byte is written with tlastarray_cs_rgs=0 and the line is not committed; wr_line and frames_avail are unchanged, and char_cnt clears for reuse of the same line. trunc_err still pulses, and the FSM goes to DISCARD.
  - Undefined: truncate-and-commit, as described in Operation.

## Test plan
- Single 16-byte frame 0x00..0x0F, tvalid constant: strobes at pointers 0x0000..0x000F. tlastarray_cs_rgs only with pointer 0x000F. frames_avail 0→1 two cycles after the tlast edge.
- Five 4-byte frames, no rd_frame_done: lines 0..3 commit to pointers 0x0000/0x0800/0x1000/0x1800. tready goes low in IDLE after the fourth frame. One rd_frame_done pulse → fifth frame written at 0x0000..0x0003, frames_avail returns to 4.
- Commit and rd_frame_done in the same cycle with frames_avail=2: frames_avail stays 2.
- 2050-byte frame, default build: trunc_err once. tlast entry at 0x07FF; bytes 2049–2050 produce no strobes; frames_avail=1. Same stimulus with WR_LOGIC_DROP_OVERSIZE_EN: frames_avail=0 and the next frame starts at 0x0000.
- tvalid toggled every other cycle on a 6-byte frame: pointers contiguous 0x0000..0x0005, no duplicate strobes.
- reset_n low for one cycle after byte 3 of a frame: all outputs 0. The next frame starts at pointer 0x0000 with frames_avail=0.
